// File: rtl/dr_mem_responder_pkg.sv
// Shared types and constants for the directory-to-memory responder.
// This package also provides the deterministic fill pattern for lines that have never been written.
package dr_mem_responder_pkg;

  localparam int SC_PADDR_BITS   = 50;
  localparam int DR_REQID_BITS   = 6;
  localparam int SC_CMD_BITS     = 4;
  localparam int SC_NODEID_BITS  = 5;
  localparam int SC_SNACK_BITS   = 3;
  localparam int MEM_LINE_CHUNKS = 8;
  localparam int MEM_CHUNK_BITS  = 64;
  localparam int SC_LINE_BITS    = MEM_LINE_CHUNKS * MEM_CHUNK_BITS;

  typedef logic [SC_PADDR_BITS-1:0]  SC_paddr_type;
  typedef logic [DR_REQID_BITS-1:0]  DR_reqid_type;
  typedef logic [SC_CMD_BITS-1:0]    SC_cmd_type;
  typedef logic [SC_NODEID_BITS-1:0] SC_nodeid_type;
  typedef logic [SC_SNACK_BITS-1:0]  SC_snack_type;
  typedef logic [SC_LINE_BITS-1:0]   SC_line_type;
  typedef logic [MEM_CHUNK_BITS-1:0] SC_chunk_type;

  localparam SC_snack_type MEM_ACK_CODE = 3'd4;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_SEND = 2'd2
  } mem_state_t;

  // Pending entry; drid is zero for prefetches and nid is zero for demand reads.
  typedef struct packed {
    logic          is_pf;
    DR_reqid_type  drid;
    SC_nodeid_type nid;
    SC_paddr_type  paddr;
  } mem_pend_t;

  // Chunk k of an unwritten line is {line address, k} zero-extended to 64 bits.
  function automatic SC_line_type mem_default_line(input SC_paddr_type paddr);
    SC_line_type line;
    line = '0;
    for (int k = 0; k < MEM_LINE_CHUNKS; k++) begin
      line[k*MEM_CHUNK_BITS +: MEM_CHUNK_BITS] = {17'd0, paddr[49:6], 3'(k)};
    end
    return line;
  endfunction

endpackage

// File: rtl/dr_mem_fifo.sv
// Parameterized valid/retry FIFO that exposes its occupancy count.
// It holds the pending read and prefetch entries of the memory responder.
module dr_mem_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_retry,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_retry,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_s;
  logic             pop_s;

  assign in_retry  = (count_r == CW'(DEPTH));
  assign out_valid = (count_r != '0);
  assign out_data  = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign push_s    = in_valid & ~in_retry;
  assign pop_s     = out_valid & ~out_retry;

  // Entry storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/dr_mem_responder.sv
// Memory-side responder: queues reads and prefetches and answers after LATENCY cycles.
// It keeps a direct-mapped line store so that writebacks are visible to later reads.
module dr_mem_responder
  import dr_mem_responder_pkg::*;
#(
  parameter int LATENCY  = 8,
  parameter int QDEPTH   = 4,
  parameter int IDX_BITS = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          drtomem_req_valid,
  output logic          drtomem_req_retry,
  input  DR_reqid_type  drtomem_req_drid,
  input  SC_cmd_type    drtomem_req_cmd,
  input  SC_paddr_type  drtomem_req_paddr,
  input  logic          drtomem_wb_valid,
  output logic          drtomem_wb_retry,
  input  SC_line_type   drtomem_wb_line,
  input  SC_paddr_type  drtomem_wb_paddr,
  input  logic          drtomem_pfreq_valid,
  output logic          drtomem_pfreq_retry,
  input  SC_nodeid_type drtomem_pfreq_nid,
  input  SC_paddr_type  drtomem_pfreq_paddr,
  output logic          memtodr_ack_valid,
  input  logic          memtodr_ack_retry,
  output DR_reqid_type  memtodr_ack_drid,
  output SC_nodeid_type memtodr_ack_nid,
  output SC_paddr_type  memtodr_ack_paddr,
  output SC_snack_type  memtodr_ack_ack,
  output SC_chunk_type  memtodr_ack_line_7,
  output SC_chunk_type  memtodr_ack_line_6,
  output SC_chunk_type  memtodr_ack_line_5,
  output SC_chunk_type  memtodr_ack_line_4,
  output SC_chunk_type  memtodr_ack_line_3,
  output SC_chunk_type  memtodr_ack_line_2,
  output SC_chunk_type  memtodr_ack_line_1,
  output SC_chunk_type  memtodr_ack_line_0
);

  localparam int CW    = $clog2(QDEPTH) + 1;
  localparam int LINES = 1 << IDX_BITS;
  // The first countdown absorbs the enqueue cycle and the IDLE cycle
  localparam logic [7:0] CNT_FIRST = 8'((LATENCY > 2) ? (LATENCY - 3) : 0);
  localparam logic [7:0] CNT_NEXT  = 8'(LATENCY - 2);

  mem_state_t           state_r;
  logic [7:0]           cnt_r;
  logic                 ack_valid_r;
  DR_reqid_type         ack_drid_r;
  SC_nodeid_type        ack_nid_r;
  SC_paddr_type         ack_paddr_r;
  SC_line_type          ack_line_r;
  SC_line_type          store_r [LINES];
  logic [LINES-1:0]     line_valid_r;

  logic                 req_push_s;
  logic                 pf_push_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 wb_fire_s;
  logic                 fifo_full_s;
  logic                 head_valid_s;
  logic                 capture_s;
  logic [CW-1:0]        count_s;
  mem_pend_t            push_entry_s;
  mem_pend_t            head_s;
  logic [IDX_BITS-1:0]  head_idx_s;
  logic [IDX_BITS-1:0]  wb_idx_s;
  SC_line_type          rd_line_s;
  logic                 unused_s;

  assign drtomem_req_retry   = reset | fifo_full_s;
  assign drtomem_pfreq_retry = reset | drtomem_req_valid | (count_s >= CW'(QDEPTH - 1));
  assign drtomem_wb_retry    = reset;

  assign req_push_s = drtomem_req_valid & ~drtomem_req_retry;
  assign pf_push_s  = drtomem_pfreq_valid & ~drtomem_pfreq_retry;
  assign push_s     = req_push_s | pf_push_s;
  assign wb_fire_s  = drtomem_wb_valid & ~drtomem_wb_retry;
  assign pop_s      = ack_valid_r & ~memtodr_ack_retry;
  assign head_idx_s = head_s.paddr[IDX_BITS+5:6];
  assign wb_idx_s   = drtomem_wb_paddr[IDX_BITS+5:6];
  assign unused_s   = ^{drtomem_req_cmd, drtomem_wb_paddr[SC_PADDR_BITS-1:IDX_BITS+6],
                        drtomem_wb_paddr[5:0]};

  // Select the entry to enqueue; pfreq_retry already excludes a simultaneous req
  always_comb begin
    push_entry_s = '0;
    if (req_push_s) begin
      push_entry_s.is_pf = 1'b0;
      push_entry_s.drid  = drtomem_req_drid;
      push_entry_s.nid   = '0;
      push_entry_s.paddr = drtomem_req_paddr;
    end else begin
      push_entry_s.is_pf = 1'b1;
      push_entry_s.drid  = '0;
      push_entry_s.nid   = drtomem_pfreq_nid;
      push_entry_s.paddr = drtomem_pfreq_paddr;
    end
  end

  dr_mem_fifo #(
    .WIDTH ($bits(mem_pend_t)),
    .DEPTH (QDEPTH)
  ) u_pend_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (push_s),
    .in_retry  (fifo_full_s),
    .in_data   (push_entry_s),
    .out_valid (head_valid_s),
    .out_retry (~pop_s),
    .out_data  (head_s),
    .count     (count_s)
  );

  // Issue-time read, forwarding a writeback that lands in the same cycle
  always_comb begin
    rd_line_s = '0;
    if (wb_fire_s && (wb_idx_s == head_idx_s)) begin
      rd_line_s = drtomem_wb_line;
    end else if (line_valid_r[head_idx_s]) begin
      rd_line_s = store_r[head_idx_s];
    end else begin
      rd_line_s = mem_default_line(head_s.paddr);
    end
  end

  // Decide when the head is read out and its response registered
  always_comb begin
    capture_s = 1'b0;
    case (state_r)
      MEM_IDLE: capture_s = head_valid_s && (LATENCY <= 2);
      MEM_WAIT: capture_s = head_valid_s && (cnt_r == 8'd0);
      MEM_SEND: capture_s = 1'b0;
      default:  capture_s = 1'b0;
    endcase
  end

  // Line data store, deliberately not reset
  always_ff @(posedge clk) begin
    if (wb_fire_s) begin
      store_r[wb_idx_s] <= drtomem_wb_line;
    end
  end

  // Per-line written flags
  always_ff @(posedge clk) begin
    if (reset) begin
      line_valid_r <= '0;
    end else if (wb_fire_s) begin
      line_valid_r[wb_idx_s] <= 1'b1;
    end
  end

  // Response sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= MEM_IDLE;
      cnt_r       <= 8'd0;
      ack_valid_r <= 1'b0;
    end else begin
      case (state_r)
        MEM_IDLE: begin
          if (capture_s) begin
            state_r     <= MEM_SEND;
            ack_valid_r <= 1'b1;
          end else if (head_valid_s) begin
            cnt_r   <= CNT_FIRST;
            state_r <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (capture_s) begin
            state_r     <= MEM_SEND;
            ack_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        MEM_SEND: begin
          if (!memtodr_ack_retry) begin
            ack_valid_r <= 1'b0;
            if ((count_s > CW'(1)) || push_s) begin
              cnt_r   <= CNT_NEXT;
              state_r <= MEM_WAIT;
            end else begin
              state_r <= MEM_IDLE;
            end
          end
        end
        default: begin
          state_r     <= MEM_IDLE;
          ack_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Response payload, held stable until popped
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_drid_r  <= '0;
      ack_nid_r   <= '0;
      ack_paddr_r <= '0;
      ack_line_r  <= '0;
    end else if (capture_s) begin
      ack_drid_r  <= head_s.drid;
      ack_nid_r   <= head_s.nid;
      ack_paddr_r <= head_s.paddr;
      ack_line_r  <= rd_line_s;
    end
  end

  assign memtodr_ack_valid  = ack_valid_r;
  assign memtodr_ack_drid   = ack_drid_r;
  assign memtodr_ack_nid    = ack_nid_r;
  assign memtodr_ack_paddr  = ack_paddr_r;
  assign memtodr_ack_ack    = MEM_ACK_CODE;
  assign memtodr_ack_line_7 = ack_line_r[7*MEM_CHUNK_BITS +: MEM_CHUNK_BITS];
  assign memtodr_ack_line_6 = ack_line_r[6*MEM_CHUNK_BITS +: MEM_CHUNK_BITS];
  assign memtodr_ack_line_5 = ack_line_r[5*MEM_CHUNK_BITS +: MEM_CHUNK_BITS];
  assign memtodr_ack_line_4 = ack_line_r[4*MEM_CHUNK_BITS +: MEM_CHUNK_BITS];
  assign memtodr_ack_line_3 = ack_line_r[3*MEM_CHUNK_BITS +: MEM_CHUNK_BITS];
  assign memtodr_ack_line_2 = ack_line_r[2*MEM_CHUNK_BITS +: MEM_CHUNK_BITS];
  assign memtodr_ack_line_1 = ack_line_r[1*MEM_CHUNK_BITS +: MEM_CHUNK_BITS];
  assign memtodr_ack_line_0 = ack_line_r[0*MEM_CHUNK_BITS +: MEM_CHUNK_BITS];

endmodule

// File: tb/tb_dr_mem_responder.sv
// Self-checking bench for dr_mem_responder: directed scenarios plus a random phase.
// A transaction-level reference model supplies the expected retries, response timing and line data.
module tb_dr_mem_responder;

  localparam int         LAT      = 8;
  localparam int         QD       = 4;
  localparam logic [2:0] ACK_CODE = 3'd4;

  logic         clk = 1'b0;
  logic         reset;
  logic         drtomem_req_valid, drtomem_req_retry;
  logic [5:0]   drtomem_req_drid;
  logic [3:0]   drtomem_req_cmd;
  logic [49:0]  drtomem_req_paddr;
  logic         drtomem_wb_valid, drtomem_wb_retry;
  logic [511:0] drtomem_wb_line;
  logic [49:0]  drtomem_wb_paddr;
  logic         drtomem_pfreq_valid, drtomem_pfreq_retry;
  logic [4:0]   drtomem_pfreq_nid;
  logic [49:0]  drtomem_pfreq_paddr;
  logic         memtodr_ack_valid, memtodr_ack_retry;
  logic [5:0]   memtodr_ack_drid;
  logic [4:0]   memtodr_ack_nid;
  logic [49:0]  memtodr_ack_paddr;
  logic [2:0]   memtodr_ack_ack;
  logic [63:0]  line7, line6, line5, line4, line3, line2, line1, line0;

  always #5 clk = ~clk;

  dr_mem_responder #(.LATENCY(LAT), .QDEPTH(QD), .IDX_BITS(6)) dut (
    .clk(clk), .reset(reset),
    .drtomem_req_valid(drtomem_req_valid), .drtomem_req_retry(drtomem_req_retry),
    .drtomem_req_drid(drtomem_req_drid), .drtomem_req_cmd(drtomem_req_cmd),
    .drtomem_req_paddr(drtomem_req_paddr),
    .drtomem_wb_valid(drtomem_wb_valid), .drtomem_wb_retry(drtomem_wb_retry),
    .drtomem_wb_line(drtomem_wb_line), .drtomem_wb_paddr(drtomem_wb_paddr),
    .drtomem_pfreq_valid(drtomem_pfreq_valid), .drtomem_pfreq_retry(drtomem_pfreq_retry),
    .drtomem_pfreq_nid(drtomem_pfreq_nid), .drtomem_pfreq_paddr(drtomem_pfreq_paddr),
    .memtodr_ack_valid(memtodr_ack_valid), .memtodr_ack_retry(memtodr_ack_retry),
    .memtodr_ack_drid(memtodr_ack_drid), .memtodr_ack_nid(memtodr_ack_nid),
    .memtodr_ack_paddr(memtodr_ack_paddr), .memtodr_ack_ack(memtodr_ack_ack),
    .memtodr_ack_line_7(line7), .memtodr_ack_line_6(line6),
    .memtodr_ack_line_5(line5), .memtodr_ack_line_4(line4),
    .memtodr_ack_line_3(line3), .memtodr_ack_line_2(line2),
    .memtodr_ack_line_1(line1), .memtodr_ack_line_0(line0)
  );

  typedef struct {
    bit          is_pf;
    logic [5:0]  drid;
    logic [4:0]  nid;
    logic [49:0] paddr;
    int          enq;
  } ref_t;

  ref_t         q[$];
  logic [511:0] mem [64];
  bit           memv [64];
  int           cyc, last_pop, checks, failures;
  logic [511:0] exp_line;
  bit           exp_ready, last_rq, last_pf;

  function automatic logic [511:0] pattern(input logic [49:0] pa);
    logic [511:0] l;
    logic [63:0]  base;
    base = 64'(pa >> 6) * 64'd8;
    for (int k = 0; k < 8; k++) l[64*k +: 64] = base + 64'(k);
    return l;
  endfunction

  function automatic logic [49:0] rnd_paddr();
    return (50'($urandom_range(0, 3)) << 12) | (50'($urandom_range(0, 7)) << 6) |
           50'($urandom_range(0, 63));
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: check outputs against the model, then advance the model at the edge.
  task automatic step();
    bit rq, pf, wb, popm;
    int e, idx;
    #1;
    rq = drtomem_req_valid && !drtomem_req_retry;
    pf = drtomem_pfreq_valid && !drtomem_pfreq_retry;
    wb = drtomem_wb_valid && !drtomem_wb_retry;
    chk("req_retry", drtomem_req_retry, reset || q.size() == QD);
    chk("pfreq_retry", drtomem_pfreq_retry, reset || drtomem_req_valid || q.size() >= QD - 1);
    chk("wb_retry", drtomem_wb_retry, reset);
    popm = 1'b0;
    if (q.size() == 0) begin
      chk("ack_idle", memtodr_ack_valid, 1'b0);
    end else begin
      e = ((q[0].enq > last_pop) ? q[0].enq : last_pop) + LAT;
      if (cyc < e) begin
        chk("ack_early", memtodr_ack_valid, 1'b0);
      end else begin
        if (!exp_ready) begin
          idx = int'(q[0].paddr[11:6]);
          exp_line  = memv[idx] ? mem[idx] : pattern(q[0].paddr);
          exp_ready = 1'b1;
        end
        chk("ack_valid", memtodr_ack_valid, 1'b1);
        chk("ack_drid", memtodr_ack_drid, q[0].is_pf ? 6'd0 : q[0].drid);
        chk("ack_nid", memtodr_ack_nid, q[0].is_pf ? q[0].nid : 5'd0);
        chk("ack_paddr", memtodr_ack_paddr, q[0].paddr);
        chk("ack_code", memtodr_ack_ack, ACK_CODE);
        chk("ack_line", {line7, line6, line5, line4, line3, line2, line1, line0}, exp_line);
        popm = !memtodr_ack_retry && !reset;
      end
    end
    @(posedge clk);
    if (reset) begin
      q.delete();
      last_pop  = -1000;
      exp_ready = 1'b0;
      foreach (memv[i]) memv[i] = 1'b0;
    end else begin
      if (popm) begin
        void'(q.pop_front());
        last_pop  = cyc;
        exp_ready = 1'b0;
      end
      if (wb) begin
        mem[int'(drtomem_wb_paddr[11:6])]  = drtomem_wb_line;
        memv[int'(drtomem_wb_paddr[11:6])] = 1'b1;
      end
      if (rq) q.push_back('{1'b0, drtomem_req_drid, 5'd0, drtomem_req_paddr, cyc});
      if (pf) q.push_back('{1'b1, 6'd0, drtomem_pfreq_nid, drtomem_pfreq_paddr, cyc});
    end
    last_rq = rq;
    last_pf = pf;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && q.size() != 0; i++) step();
    chk("drain_timeout", q.size() == 0, 1'b1);
    repeat (3) step();
  endtask

  task automatic send_req(input logic [5:0] drid, input logic [49:0] pa);
    drtomem_req_valid = 1'b1;
    drtomem_req_drid  = drid;
    drtomem_req_paddr = pa;
    drtomem_req_cmd   = 4'd1;
    step();
    drtomem_req_valid = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    drtomem_req_valid = 1'b0; drtomem_req_drid = '0; drtomem_req_cmd = '0; drtomem_req_paddr = '0;
    drtomem_wb_valid = 1'b0; drtomem_wb_line = '0; drtomem_wb_paddr = '0;
    drtomem_pfreq_valid = 1'b0; drtomem_pfreq_nid = '0; drtomem_pfreq_paddr = '0;
    memtodr_ack_retry = 1'b0;
    cyc = 0; last_pop = -1000; checks = 0; failures = 0; exp_ready = 1'b0;
    last_rq = 1'b0; last_pf = 1'b0;
    foreach (memv[i]) memv[i] = 1'b0;
    @(negedge clk);
    repeat (3) step();
    reset = 1'b0;
    step();

    // Read of an unwritten line arrives after LATENCY cycles with the fill pattern
    send_req(6'd3, 50'h1000);
    repeat (7) step();
    chk("t1_valid", memtodr_ack_valid, 1'b1);
    chk("t1_line0", line0, 64'h200);
    chk("t1_line7", line7, 64'h207);
    drain(40);

    // Writeback then read of the same line
    drtomem_wb_valid = 1'b1;
    drtomem_wb_paddr = 50'h1040;
    for (int k = 0; k < 8; k++) drtomem_wb_line[64*k +: 64] = 64'hA5A5_0000_0000_0000 | 64'(k);
    step();
    drtomem_wb_valid = 1'b0;
    send_req(6'd5, 50'h1040);
    repeat (7) step();
    chk("t2_line3", line3, 64'hA5A5_0000_0000_0003);
    drain(40);

    // Stalled response must hold its payload
    memtodr_ack_retry = 1'b1;
    send_req(6'd7, 50'h2000);
    send_req(6'd8, 50'h2040);
    repeat (30) step();
    memtodr_ack_retry = 1'b0;
    drain(60);

    // Fill the queue while responses are stalled
    memtodr_ack_retry = 1'b1;
    n = 0;
    drtomem_req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drtomem_req_drid  = 6'(10 + n);
      drtomem_req_paddr = 50'h2000 + 50'(n * 64);
      step();
      if (last_rq) n++;
    end
    drtomem_req_valid = 1'b0;
    repeat (10) step();
    chk("fill_full", drtomem_req_retry, 1'b1);
    memtodr_ack_retry = 1'b0;
    step();
    memtodr_ack_retry = 1'b1;
    chk("fill_one_drained", drtomem_req_retry, 1'b0);
    memtodr_ack_retry = 1'b0;
    drain(100);

    // req and pfreq together: req wins, pfreq goes the next cycle
    drtomem_req_valid = 1'b1; drtomem_req_drid = 6'd9; drtomem_req_paddr = 50'h4000;
    drtomem_pfreq_valid = 1'b1; drtomem_pfreq_nid = 5'd2; drtomem_pfreq_paddr = 50'h4080;
    step();
    chk("pf_refused", last_pf, 1'b0);
    drtomem_req_valid = 1'b0;
    step();
    chk("pf_accepted", last_pf, 1'b1);
    drtomem_pfreq_valid = 1'b0;
    drain(60);

    // Writeback landing in the issue cycle is forwarded; one during SEND is not
    send_req(6'd11, 50'h3000);
    repeat (6) step();
    drtomem_wb_valid = 1'b1; drtomem_wb_paddr = 50'h3000;
    for (int k = 0; k < 16; k++) drtomem_wb_line[32*k +: 32] = $urandom;
    step();
    for (int k = 0; k < 16; k++) drtomem_wb_line[32*k +: 32] = $urandom;
    step();
    drtomem_wb_valid = 1'b0;
    drain(40);

    // Reset while waiting drops pending entries
    send_req(6'd12, 50'h5000);
    send_req(6'd13, 50'h5040);
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (12) step();
    send_req(6'd14, 50'h5040);
    repeat (7) step();
    chk("post_reset_valid", memtodr_ack_valid, 1'b1);
    chk("post_reset_drid", memtodr_ack_drid, 6'd14);
    drain(40);

    // Random traffic; sources hold payload while retried
    for (int i = 0; i < 500; i++) begin
      if (!drtomem_req_valid || last_rq) begin
        drtomem_req_valid = ($urandom_range(0, 2) == 0);
        drtomem_req_drid  = 6'($urandom);
        drtomem_req_cmd   = 4'($urandom);
        drtomem_req_paddr = rnd_paddr();
      end
      if (!drtomem_pfreq_valid || last_pf) begin
        drtomem_pfreq_valid = ($urandom_range(0, 3) == 0);
        drtomem_pfreq_nid   = 5'($urandom);
        drtomem_pfreq_paddr = rnd_paddr();
      end
      drtomem_wb_valid = ($urandom_range(0, 3) == 0);
      drtomem_wb_paddr = rnd_paddr();
      for (int k = 0; k < 16; k++) drtomem_wb_line[32*k +: 32] = $urandom;
      memtodr_ack_retry = ($urandom_range(0, 3) == 0);
      step();
    end
    drtomem_req_valid = 1'b0; drtomem_pfreq_valid = 1'b0; drtomem_wb_valid = 1'b0;
    memtodr_ack_retry = 1'b0;
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
